// File: rtl/scan_test_controller.sv
// Scan-test sequencer: shift a pattern into a scan chain, pulse one capture
// cycle, unload the response, then grade it against an expected vector.
module scan_test_controller #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PATTERN,
    input  logic [CHAIN_LEN-1:0] EXPECTED,
    input  logic                 SO,
    output logic                 SI,
    output logic                 SE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESPONSE,
    output logic                 PASS,
    output logic                 FAIL,
    output logic [CNT_W-1:0]     FAIL_CNT
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        REPORT
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n, idx;
    logic [CHAIN_LEN-1:0] pat_q, exp_q, pat_sh, resp_n;
    logic                 accept, cnt_last, unload_end, mismatch;

    assign cnt_last = (cnt == LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    accept  = 1'b1;
                    cnt_n   = '0;
                    state_n = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = CAPTURE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            CAPTURE: state_n = SHIFT_OUT;
            SHIFT_OUT: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = REPORT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Both directions walk the chain MSB first, so one index serves both.
    always_comb begin
        idx    = LAST - cnt;
        pat_sh = pat_q >> idx;
        resp_n = RESPONSE;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (CW'(i) == idx) resp_n[i] = SO;
        end
    end

    assign SI         = (state == SHIFT_IN) & pat_sh[0];
    assign SE         = (state == SHIFT_IN) | (state == SHIFT_OUT);
    assign BUSY       = (state != IDLE);
    assign DONE       = (state == REPORT);
    assign unload_end = (state == SHIFT_OUT) & cnt_last;
    assign mismatch   = (resp_n != exp_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            pat_q    <= '0;
            exp_q    <= '0;
            RESPONSE <= '0;
            PASS     <= 1'b0;
            FAIL     <= 1'b0;
            FAIL_CNT <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                pat_q <= PATTERN;
                exp_q <= EXPECTED;
                PASS  <= 1'b0;
                FAIL  <= 1'b0;
            end
            if (state == SHIFT_OUT) RESPONSE <= resp_n;
            // Grade on the last unload edge so PASS/FAIL are valid with DONE.
            if (unload_end) begin
                PASS <= !mismatch;
                FAIL <= mismatch;
                if (mismatch && FAIL_CNT != '1) begin
                    FAIL_CNT <= FAIL_CNT + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: behavioural scan chain, vector table,
// hand-written corner sequences and randomized runs against a run-level model.
module tb_scan_test_controller;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RST_N, START, SO, SI, SE, BUSY, DONE, PASS, FAIL;
    logic [N-1:0]  PATTERN, EXPECTED, RESPONSE;
    logic [CW-1:0] FAIL_CNT;

    logic [N-1:0] chain = '0;
    logic [N-1:0] di    = '0;
    bit           stuck0 = 1'b0;

    int passed = 0;
    int total = 0;
    int done_seen = 0;
    int busy_seen = 0;
    int model_fc = 0;

    typedef struct {
        logic [N-1:0] pat;
        logic [N-1:0] expv;
        logic [N-1:0] dv;
        bit           stuck;
        bit           poke;
        logic [N-1:0] resp;
        bit           pass;
        int           fc;
    } vec_t;

    vec_t tbl[8];

    scan_test_controller #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .PATTERN(PATTERN),
        .EXPECTED(EXPECTED), .SO(SO), .SI(SI), .SE(SE), .BUSY(BUSY),
        .DONE(DONE), .RESPONSE(RESPONSE), .PASS(PASS), .FAIL(FAIL),
        .FAIL_CNT(FAIL_CNT)
    );

    always #5 CLK = ~CLK;

    // Scan chain: chain[i] is flop i+1; flop 1 takes SI, the last flop drives SO.
    always @(posedge CLK) begin
        if (SE) chain <= {chain[N-2:0], SI};
        else    chain <= di;
    end
    assign SO = stuck0 ? 1'b0 : chain[N-1];

    always @(posedge CLK) begin
        if (DONE) done_seen++;
        if (BUSY) busy_seen++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    task automatic run(input logic [N-1:0] pat, input logic [N-1:0] expv,
                       input logic [N-1:0] dv, input bit stk, input bit poke,
                       input logic [N-1:0] er, input bit ep, input int efc);
        int lat, d0, b0;
        d0 = done_seen;
        b0 = busy_seen;
        stuck0 = stk;
        PATTERN = pat;
        EXPECTED = expv;
        di = dv;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int c = 0; c < N; c++) begin
            check("si_in", 32'(SI), 32'(pat[N-1-c]));
            check("se_in", 32'(SE), 32'd1);
            check("busy_in", 32'(BUSY), 32'd1);
            if (poke) begin
                START = 1'b1;
                PATTERN = ~pat;
                EXPECTED = ~expv;
            end
            @(negedge CLK);
            START = 1'b0;
        end
        check("chain_loaded", 32'(chain), 32'(pat));
        check("se_capture", 32'(SE), 32'd0);
        lat = N;
        while (!DONE && lat < 40) begin
            if (lat > N) begin
                check("se_out", 32'(SE), 32'd1);
                check("si_out", 32'(SI), 32'd0);
            end
            START = poke;
            @(negedge CLK);
            lat++;
        end
        START = 1'b0;
        check("done_latency", 32'(lat), 32'(2 * N + 1));
        check("response", 32'(RESPONSE), 32'(er));
        check("pass", 32'(PASS), 32'(ep));
        check("fail", 32'(FAIL), 32'(!ep));
        check("fail_cnt", 32'(FAIL_CNT), 32'(efc));
        @(negedge CLK);
        check("done_pulse", 32'(DONE), 32'd0);
        check("busy_end", 32'(BUSY), 32'd0);
        check("done_count", 32'(done_seen - d0), 32'd1);
        check("busy_cycles", 32'(busy_seen - b0), 32'(2 * N + 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] vals[3];
        logic [N-1:0] rp, rd, rx, er;
        bit           rs, ep;
        int           w, idle, d0;

        tbl[0] = '{4'b1011, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b1, 0};
        tbl[1] = '{4'b1011, 4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 1};
        tbl[2] = '{4'b1011, 4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 2};
        tbl[3] = '{4'b1011, 4'b0110, 4'b0110, 1'b1, 1'b1, 4'b0000, 1'b0, 3};
        tbl[4] = '{4'b0111, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 3};
        tbl[5] = '{4'b1000, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 3};
        tbl[6] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1111, 1'b1, 3};
        tbl[7] = '{4'b0101, 4'b1000, 4'b1001, 1'b0, 1'b0, 4'b1001, 1'b0, 3};

        RST_N = 1'b0;
        START = 1'b0;
        PATTERN = '0;
        EXPECTED = '0;
        repeat (2) @(negedge CLK);
        check("rst_se", 32'(SE), 32'd0);
        check("rst_si", 32'(SI), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_resp", 32'(RESPONSE), 32'd0);
        check("rst_pass_fail", 32'({PASS, FAIL}), 32'd0);
        check("rst_fail_cnt", 32'(FAIL_CNT), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i].pat, tbl[i].expv, tbl[i].dv, tbl[i].stuck, tbl[i].poke,
                tbl[i].resp, tbl[i].pass, tbl[i].fc);
        end

        // Asynchronous reset in the middle of the unload.
        stuck0 = 1'b0;
        d0 = done_seen;
        PATTERN = 4'b1011;
        EXPECTED = 4'b0110;
        di = 4'b0110;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        check("pre_reset_busy", 32'(BUSY), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_se", 32'(SE), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_done", 32'(DONE), 32'd0);
        check("mid_rst_resp", 32'(RESPONSE), 32'd0);
        check("mid_rst_pass_fail", 32'({PASS, FAIL}), 32'd0);
        check("mid_rst_fail_cnt", 32'(FAIL_CNT), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("no_done_after_rst", 32'(done_seen - d0), 32'd0);
        model_fc = 0;
        run(4'b1011, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b1, 0);

        // START held high: back-to-back runs, one idle cycle apart.
        vals[0] = 4'b0110;
        vals[1] = 4'b1001;
        vals[2] = 4'b0011;
        PATTERN = 4'b1100;
        di = vals[0];
        EXPECTED = vals[0];
        START = 1'b1;
        for (int r = 0; r < 3; r++) begin
            w = 0;
            idle = 0;
            do begin
                @(negedge CLK);
                w++;
                if (!BUSY) idle++;
            end while (!DONE && w < 40);
            check("b2b_gap", 32'(w), 32'(r == 0 ? 2 * N + 2 : 2 * N + 3));
            check("b2b_idle", 32'(idle), 32'(r == 0 ? 0 : 1));
            check("b2b_resp", 32'(RESPONSE), 32'(vals[r]));
            check("b2b_pass", 32'(PASS), 32'd1);
            if (r < 2) begin
                di = vals[r+1];
                EXPECTED = vals[r+1];
            end
        end
        START = 1'b0;
        repeat (2) @(negedge CLK);
        check("b2b_stop", 32'(BUSY), 32'd0);

        // Randomized runs graded by a run-level model.
        for (int k = 0; k < 24; k++) begin
            rp = N'($urandom);
            rd = N'($urandom);
            rx = ($urandom_range(0, 1) == 1) ? rd : N'($urandom);
            rs = ($urandom_range(0, 3) == 0);
            er = rs ? '0 : rd;
            ep = (er == rx);
            if (!ep && model_fc < (1 << CW) - 1) model_fc++;
            run(rp, rx, rd, rs, bit'($urandom_range(0, 1)), er, ep, model_fc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
